// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC sequencing, byte-wide instruction memory and IF/ID feed for the 5-stage pipeline
module instruction_fetch_unit #(
  parameter int          IMEM_BYTES = 64,
  parameter logic [63:0] RESET_PC   = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_write,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  input  logic        imem_wr_en,
  input  logic [63:0] imem_wr_addr,
  input  logic [31:0] imem_wr_data,
  output logic [63:0] PC_out,
  output logic [31:0] Instruction_out,
  output logic        fetch_valid,
  output logic        flush_ifid,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);
  localparam int AW = $clog2(IMEM_BYTES);
  localparam logic [1:0] BOOT  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FAULT = 2'd2;
  logic [1:0]    state_q, state_d;
  logic [63:0]   pc_q, pc_d;
  logic [31:0]   count_q, count_d;
  logic          fault_q, fault_d;
  logic [7:0]    mem [IMEM_BYTES];
  logic [AW-1:0] ridx, widx;
  logic          rd_ok, wr_ok;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    fault_d = fault_q;
    if (state_q == BOOT) begin
      state_d = RUN;
    end else if (state_q == RUN) begin
      if (branch_taken && branch_target[1:0] == 2'b00) begin
        pc_d    = branch_target;
        count_d = count_q + 32'd1;
      end else if (branch_taken) begin
        fault_d = 1'b1;
        state_d = FAULT;
      end else if (pc_write) begin
        pc_d    = pc_q + 64'd4;
        count_d = count_q + 32'd1;
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      count_q <= 32'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      fault_q <= fault_d;
    end
  end
  // Memory has no reset so it can be preloaded while the core is held in reset.
  assign widx  = {imem_wr_addr[AW-1:2], 2'b00};
  assign wr_ok = {imem_wr_addr[63:2], 2'b00} < 64'(IMEM_BYTES);
  always_ff @(posedge clk) begin
    if (imem_wr_en && wr_ok) begin
      mem[widx]          <= imem_wr_data[7:0];
      mem[widx + AW'(1)] <= imem_wr_data[15:8];
      mem[widx + AW'(2)] <= imem_wr_data[23:16];
      mem[widx + AW'(3)] <= imem_wr_data[31:24];
    end
  end
  assign ridx  = pc_q[AW-1:0];
  assign rd_ok = ({1'b0, pc_q} + 65'd3) < 65'(IMEM_BYTES);
  assign Instruction_out = (state_q == RUN && rd_ok) ?
    {mem[ridx + AW'(3)], mem[ridx + AW'(2)], mem[ridx + AW'(1)], mem[ridx]} : 32'b0;
  assign PC_out      = pc_q;
  assign fetch_valid = state_q == RUN;
  assign flush_ifid  = branch_taken;
  assign fetch_fault = fault_q;
  assign fetch_count = count_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed scenario tasks with hand-computed expectations
module tb_instruction_fetch_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pc_write = 1'b0;
  logic        branch_taken = 1'b0;
  logic [63:0] branch_target = 64'h0;
  logic        imem_wr_en = 1'b0;
  logic [63:0] imem_wr_addr = 64'h0;
  logic [31:0] imem_wr_data = 32'h0;
  logic [63:0] PC_out;
  logic [31:0] Instruction_out;
  logic        fetch_valid;
  logic        flush_ifid;
  logic        fetch_fault;
  logic [31:0] fetch_count;
  int total = 0;
  int bad = 0;

  instruction_fetch_unit #(.IMEM_BYTES(64), .RESET_PC(64'h0)) dut (
    .clk(clk), .reset(reset), .pc_write(pc_write), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_wr_en(imem_wr_en), .imem_wr_addr(imem_wr_addr),
    .imem_wr_data(imem_wr_data), .PC_out(PC_out), .Instruction_out(Instruction_out),
    .fetch_valid(fetch_valid), .flush_ifid(flush_ifid), .fetch_fault(fetch_fault),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [63:0] a, input logic [31:0] d);
    imem_wr_en = 1'b1; imem_wr_addr = a; imem_wr_data = d;
    tick();
    imem_wr_en = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    tick();
    wr(64'h0, 32'h11111111);
    wr(64'h4, 32'h22222222);
    wr(64'h8, 32'h33333333);
    total++; if (PC_out !== 64'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", PC_out); end
    total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", fetch_valid); end
    total++; if (Instruction_out !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h exp=0", Instruction_out); end
    total++; if (fetch_count !== 32'h0) begin bad++; $display("FAIL reset_count got=%0d exp=0", fetch_count); end
    total++; if (fetch_fault !== 1'b0) begin bad++; $display("FAIL reset_fault got=%b exp=0", fetch_fault); end
    branch_taken = 1'b1; #1;
    total++; if (flush_ifid !== 1'b1) begin bad++; $display("FAIL reset_flush got=%b exp=1", flush_ifid); end
    branch_taken = 1'b0; #1;
    total++; if (flush_ifid !== 1'b0) begin bad++; $display("FAIL reset_flush_low got=%b exp=0", flush_ifid); end
  endtask

  task automatic test_sequential();
    pc_write = 1'b1;
    reset = 1'b1; #1;
    total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL boot_valid got=%b exp=0", fetch_valid); end
    tick();
    total++; if (PC_out !== 64'h0 || Instruction_out !== 32'h11111111 || fetch_valid !== 1'b1)
      begin bad++; $display("FAIL seq0 pc=%h instr=%h valid=%b exp pc=0 instr=11111111 valid=1", PC_out, Instruction_out, fetch_valid); end
    tick();
    total++; if (PC_out !== 64'h4 || Instruction_out !== 32'h22222222 || fetch_count !== 32'd1)
      begin bad++; $display("FAIL seq4 pc=%h instr=%h cnt=%0d exp pc=4 instr=22222222 cnt=1", PC_out, Instruction_out, fetch_count); end
    tick();
    total++; if (PC_out !== 64'h8 || Instruction_out !== 32'h33333333 || fetch_count !== 32'd2)
      begin bad++; $display("FAIL seq8 pc=%h instr=%h cnt=%0d exp pc=8 instr=33333333 cnt=2", PC_out, Instruction_out, fetch_count); end
    tick();
    total++; if (PC_out !== 64'hc || fetch_count !== 32'd3)
      begin bad++; $display("FAIL seq12 pc=%h cnt=%0d exp pc=c cnt=3", PC_out, fetch_count); end
  endtask

  task automatic test_stall();
    branch_taken = 1'b1; branch_target = 64'h4;
    tick();
    branch_taken = 1'b0; pc_write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (PC_out !== 64'h4 || Instruction_out !== 32'h22222222 || fetch_count !== 32'd4)
        begin bad++; $display("FAIL stall%0d pc=%h instr=%h cnt=%0d exp pc=4 instr=22222222 cnt=4", i, PC_out, Instruction_out, fetch_count); end
    end
    pc_write = 1'b1;
    tick();
    total++; if (PC_out !== 64'h8 || fetch_count !== 32'd5)
      begin bad++; $display("FAIL stall_resume pc=%h cnt=%0d exp pc=8 cnt=5", PC_out, fetch_count); end
  endtask

  task automatic test_redirect_beats_stall();
    branch_taken = 1'b1; branch_target = 64'h0; pc_write = 1'b0; #1;
    total++; if (flush_ifid !== 1'b1) begin bad++; $display("FAIL redir_flush got=%b exp=1", flush_ifid); end
    tick();
    branch_taken = 1'b0; #1;
    total++; if (PC_out !== 64'h0 || fetch_count !== 32'd6 || flush_ifid !== 1'b0)
      begin bad++; $display("FAIL redir pc=%h cnt=%0d flush=%b exp pc=0 cnt=6 flush=0", PC_out, fetch_count, flush_ifid); end
  endtask

  task automatic test_bounds_wrap();
    branch_taken = 1'b1; branch_target = 64'h40;
    tick();
    total++; if (PC_out !== 64'h40 || fetch_valid !== 1'b1 || Instruction_out !== 32'h0 || fetch_count !== 32'd7)
      begin bad++; $display("FAIL oob pc=%h valid=%b instr=%h cnt=%0d exp pc=40 valid=1 instr=0 cnt=7", PC_out, fetch_valid, Instruction_out, fetch_count); end
    branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    total++; if (PC_out !== 64'hFFFF_FFFF_FFFF_FFFC || Instruction_out !== 32'h0 || fetch_count !== 32'd8)
      begin bad++; $display("FAIL top pc=%h instr=%h cnt=%0d exp pc=fffffffffffffffc instr=0 cnt=8", PC_out, Instruction_out, fetch_count); end
    branch_taken = 1'b0; pc_write = 1'b1;
    tick();
    total++; if (PC_out !== 64'h0 || Instruction_out !== 32'h11111111 || fetch_count !== 32'd9)
      begin bad++; $display("FAIL wrap pc=%h instr=%h cnt=%0d exp pc=0 instr=11111111 cnt=9", PC_out, Instruction_out, fetch_count); end
  endtask

  task automatic test_write_same_word();
    pc_write = 1'b0;
    imem_wr_en = 1'b1; imem_wr_addr = 64'h0; imem_wr_data = 32'hDEADBEEF; #1;
    total++; if (Instruction_out !== 32'h11111111) begin bad++; $display("FAIL wr_before got=%h exp=11111111", Instruction_out); end
    tick();
    imem_wr_en = 1'b0; #1;
    total++; if (Instruction_out !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_after got=%h exp=deadbeef", Instruction_out); end
    wr(64'h44, 32'hCAFEBABE);
    branch_taken = 1'b1; branch_target = 64'h4;
    tick();
    branch_taken = 1'b0; #1;
    total++; if (PC_out !== 64'h4 || Instruction_out !== 32'h22222222 || fetch_count !== 32'd10)
      begin bad++; $display("FAIL wr_drop pc=%h instr=%h cnt=%0d exp pc=4 instr=22222222 cnt=10", PC_out, Instruction_out, fetch_count); end
  endtask

  task automatic test_fault();
    branch_taken = 1'b1; branch_target = 64'h6;
    tick();
    branch_taken = 1'b0; pc_write = 1'b1;
    total++; if (fetch_fault !== 1'b1 || fetch_valid !== 1'b0 || Instruction_out !== 32'h0)
      begin bad++; $display("FAIL fault fault=%b valid=%b instr=%h exp fault=1 valid=0 instr=0", fetch_fault, fetch_valid, Instruction_out); end
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (PC_out !== 64'h4 || fetch_count !== 32'd10 || fetch_fault !== 1'b1)
        begin bad++; $display("FAIL fault_hold%0d pc=%h cnt=%0d fault=%b exp pc=4 cnt=10 fault=1", i, PC_out, fetch_count, fetch_fault); end
    end
    reset = 1'b0; #1;
    total++; if (PC_out !== 64'h0 || fetch_fault !== 1'b0 || fetch_count !== 32'd0 || fetch_valid !== 1'b0)
      begin bad++; $display("FAIL fault_reset pc=%h fault=%b cnt=%0d valid=%b exp pc=0 fault=0 cnt=0 valid=0", PC_out, fetch_fault, fetch_count, fetch_valid); end
    tick();
    reset = 1'b1; branch_taken = 1'b1; branch_target = 64'h8;
    tick();
    branch_taken = 1'b0;
    total++; if (PC_out !== 64'h0 || fetch_valid !== 1'b1 || fetch_count !== 32'd0)
      begin bad++; $display("FAIL boot_ignore pc=%h valid=%b cnt=%0d exp pc=0 valid=1 cnt=0", PC_out, fetch_valid, fetch_count); end
    tick();
    total++; if (PC_out !== 64'h4 || fetch_count !== 32'd1)
      begin bad++; $display("FAIL restart pc=%h cnt=%0d exp pc=4 cnt=1", PC_out, fetch_count); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_beats_stall();
    test_bounds_wrap();
    test_write_same_word();
    test_fault();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Front end of the 5-stage pipeline; drives the IF/ID register.
- Holds the PC and a byte-addressed little-endian instruction memory, and presents {PC, instruction} every cycle.
- Redirects on a taken branch from MEM and raises the IF/ID flush in the same cycle.
- Freezes the PC when the hazard unit deasserts pc_write.

Parameters:
IMEM_BYTES, 64, instruction memory size in bytes (multiple of 4)
RESET_PC, 64'h0, PC value loaded on reset

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset)
pc_write  input  1  from hazard unit; 1 = advance PC, 0 = stall (hold PC)
branch_taken  input  1  taken branch/jump resolved in MEM (PCSrc)
branch_target  input  64  redirect address, valid when branch_taken=1
imem_wr_en  input  1  instruction memory load strobe
imem_wr_addr  input  64  byte address of word to load; bits [1:0] ignored
imem_wr_data  input  32  word to load, stored little-endian
PC_out  output  64  address of the instruction being fetched (to IF/ID PC_in)
Instruction_out  output  32  fetched instruction (to IF/ID instruction_in)
fetch_valid  output  1  1 when PC_out/Instruction_out are meaningful
flush_ifid  output  1  flush request to IF/ID; equals branch_taken combinationally
fetch_fault  output  1  sticky; set on a misaligned redirect target
fetch_count  output  32  number of PC updates since reset; wraps modulo 2^32

Behaviour:
- reset=0, asynchronous:
  - PC=RESET_PC, state=BOOT, fetch_count=0, fetch_fault=0.
  - Memory contents are not cleared.
- Outputs during reset: PC_out=RESET_PC, fetch_valid=0, Instruction_out=0, flush_ifid follows branch_taken.
- State machine, 3 states:
  - BOOT: entered on reset. fetch_valid=0. PC holds. Unconditional move to RUN on the first clk edge after reset deasserts. branch_taken is ignored in BOOT, but flush_ifid still mirrors it.
  - RUN: fetch_valid=1. PC update at each clk edge, in priority order:
    1) branch_taken=1 and branch_target[1:0]==0: PC<=branch_target; fetch_count++. This overrides pc_write=0, i.e. a redirect beats a stall.
    2) branch_taken=1 and branch_target[1:0]!=0: PC holds; fetch_fault<=1; state<=FAULT.
    3) pc_write=1: PC<=PC+4, wrapping modulo 2^64; fetch_count++.
    4) otherwise PC holds and fetch_count holds.
  - FAULT: fetch_valid=0, Instruction_out=0, PC frozen, fetch_count frozen. Left only by reset.
- Fetch read path is combinational from the current PC, zero cycles of latency:
  - Instruction_out = {mem[PC+3], mem[PC+2], mem[PC+1], mem[PC]} when PC+3 < IMEM_BYTES and state==RUN; otherwise 32'b0.
  - Out-of-range fetch: Instruction_out=0 with fetch_valid=1. A zero instruction is the pipeline bubble.
- PC_out = PC in every state.
- flush_ifid = branch_taken, purely combinational. IF/ID samples it at the same edge the PC redirects, so the wrong-path instruction is zeroed in IF/ID. There is no extra delay.
- Memory load:
  - Synchronous write at the clk edge when imem_wr_en=1. Word address = imem_wr_addr with [1:0] cleared. Writes at or beyond IMEM_BYTES are dropped.
  - Writes are allowed in every state, including during reset.
  - Simultaneous write and fetch to the same word: Instruction_out shows the old word before the edge and the new word after it.
- Stall with pc_write=0: PC_out/Instruction_out remain stable for as many cycles as the stall lasts.
- Asserting reset mid-stream discards any in-flight redirect. After release, fetch restarts at RESET_PC via BOOT.

Test Plan:
- Load words 0x11111111, 0x22222222, 0x33333333 at 0, 4, 8; release reset; pc_write=1 -> cycle 0 (BOOT): fetch_valid=0. Then PC_out 0, 4, 8 with matching Instruction_out. fetch_count=3 after the third advance.
- In RUN at PC=4, hold pc_write=0 for 3 cycles -> PC_out=4 and Instruction_out=0x22222222 stable; fetch_count unchanged; PC=8 one edge after pc_write returns to 1.
- At PC=8, branch_taken=1, branch_target=0x0, pc_write=0 in the same cycle -> flush_ifid=1 that cycle; next PC_out=0 (redirect beats stall); fetch_count+1.
- branch_taken=1, branch_target=0x6 -> fetch_fault=1, fetch_valid=0, Instruction_out=0, PC frozen over 5 further cycles. Pulse reset=0 -> PC_out=RESET_PC, fetch_fault=0, BOOT then RUN.
- Redirect to IMEM_BYTES (0x40) -> fetch_valid=1, Instruction_out=0. Redirect to 64'hFFFFFFFFFFFFFFFC then advance -> PC wraps to 0 and fetches 0x11111111.
- Write 0xDEADBEEF to address 0 while PC=0 -> Instruction_out=0x11111111 before the edge and 0xDEADBEEF after it. Write to 0x44 -> dropped; memory is unchanged.
